// File: rtl/branch_resolve_unit_if.sv
// Branch-resolve bundle: pipeline-side inputs and predictor/front-end outputs.
// The slave modport is the resolve unit; the master modport is its environment.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             if_valid;
  logic             if_prediction;
  logic             ex_branch;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_pc;
  logic [PC_W-1:0]  ex_target;
  logic             branchex;
  logic             outcome;
  logic             flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport slave (
    input  stall, if_valid, if_prediction, ex_branch, ex_taken, ex_pc, ex_target,
    output branchex, outcome, flush, redirect_valid, redirect_pc, branch_count,
           mispredict_count
  );

  modport master (
    output stall, if_valid, if_prediction, ex_branch, ex_taken, ex_pc, ex_target,
    input  branchex, outcome, flush, redirect_valid, redirect_pc, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries predictions IF->ID->EX, resolves them against the EX outcome, and drives
// predictor update, front-end redirect/flush and saturating prediction statistics.
module branch_resolve_unit #(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_resolve_unit_if.slave  bus
);

  typedef enum logic {StIdle, StFlush} state_e;

  localparam logic [3:0]       FlushInit = 4'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0]  PcFour    = PC_W'(4);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic             r_flush;
  logic             r_id_valid, r_id_pred;
  logic             r_ex_valid, r_ex_pred;
  logic             r_branchex, r_outcome, r_redirect_valid;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_count, r_mispredict_count;

  logic             w_resolve;
  logic             w_mispredict;
  logic [PC_W-1:0]  w_redirect_pc;

  assign w_resolve     = bus.ex_branch & r_ex_valid & ~bus.stall & (r_state == StIdle);
  assign w_mispredict  = w_resolve & (r_ex_pred != bus.ex_taken);
  assign w_redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PcFour;

  // Flush FSM; flush rises on the same edge that registers the redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_mispredict) begin
            r_state <= StFlush;
            r_cnt   <= FlushInit;
            r_flush <= 1'b1;
          end
        end
        StFlush: begin
          if (r_cnt == 4'd0) begin
            r_state <= StIdle;
            r_flush <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Metadata pipe: flush clears valids even under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_pred  <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_pred  <= 1'b0;
    end else if (r_flush) begin
      r_id_valid <= 1'b0;
      r_ex_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_id_valid <= bus.if_valid;
      r_id_pred  <= bus.if_prediction;
      r_ex_valid <= r_id_valid;
      r_ex_pred  <= r_id_pred;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branchex         <= 1'b0;
      r_outcome          <= 1'b0;
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_branchex       <= w_resolve;
      r_redirect_valid <= w_mispredict;
      if (w_resolve) begin
        r_outcome <= bus.ex_taken;
        if (r_branch_count != '1) r_branch_count <= r_branch_count + CntOne;
      end
      if (w_mispredict) begin
        r_redirect_pc <= w_redirect_pc;
        if (r_mispredict_count != '1) r_mispredict_count <= r_mispredict_count + CntOne;
      end
    end
  end

  assign bus.branchex         = r_branchex;
  assign bus.outcome          = r_outcome;
  assign bus.flush            = r_flush;
  assign bus.redirect_valid   = r_redirect_valid;
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: a wide-counter and a 4-bit-counter instance share stimulus and
// are compared every cycle against a cycle-level behavioural model.
module tb_branch_resolve_unit;
  localparam int unsigned PC_W = 64;
  localparam int unsigned FC   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_W(PC_W), .CNT_W(32)) bus ();
  branch_resolve_unit_if #(.PC_W(PC_W), .CNT_W(4))  bus_s ();

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(32), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(4), .FLUSH_CYCLES(FC)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit              m_id_v, m_id_p, m_ex_v, m_ex_p;
  int              m_flush_left;
  bit              m_bx, m_out, m_rv;
  logic [63:0]     m_rpc;
  longint unsigned m_bc, m_mc;

  function automatic logic [63:0] sat(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit st, input bit iv, input bit ip, input bit eb, input bit et,
                       input logic [63:0] pc, input logic [63:0] tgt);
    bus.stall = st;     bus.if_valid = iv;     bus.if_prediction = ip;
    bus.ex_branch = eb; bus.ex_taken = et;     bus.ex_pc = pc;  bus.ex_target = tgt;
    bus_s.stall = st;   bus_s.if_valid = iv;   bus_s.if_prediction = ip;
    bus_s.ex_branch = eb; bus_s.ex_taken = et; bus_s.ex_pc = pc; bus_s.ex_target = tgt;
  endtask

  task automatic model_reset();
    m_id_v = 0; m_id_p = 0; m_ex_v = 0; m_ex_p = 0;
    m_flush_left = 0;
    m_bx = 0; m_out = 0; m_rv = 0; m_rpc = '0;
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_edge();
    bit flushing, res, mis;
    flushing = (m_flush_left > 0);
    res = bus.ex_branch && m_ex_v && !bus.stall && !flushing;
    mis = res && (m_ex_p != bus.ex_taken);
    if (flushing) begin
      m_id_v = 0; m_ex_v = 0;
    end else if (!bus.stall) begin
      m_ex_v = m_id_v; m_ex_p = m_id_p;
      m_id_v = bus.if_valid; m_id_p = bus.if_prediction;
    end
    if (mis) m_flush_left = FC;
    else if (flushing) m_flush_left--;
    m_bx = res;
    m_rv = mis;
    if (res) begin
      m_out = bus.ex_taken;
      m_bc++;
    end
    if (mis) begin
      m_rpc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 64'd4;
      m_mc++;
    end
  endtask

  task automatic check_all();
    chk("branchex", {63'd0, bus.branchex}, {63'd0, m_bx});
    chk("outcome", {63'd0, bus.outcome}, {63'd0, m_out});
    chk("flush", {63'd0, bus.flush}, {63'd0, m_flush_left > 0});
    chk("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, m_rv});
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("branch_count", {32'd0, bus.branch_count}, sat(m_bc, 64'hFFFF_FFFF));
    chk("mispredict_count", {32'd0, bus.mispredict_count}, sat(m_mc, 64'hFFFF_FFFF));
    chk("s_branch_count", {60'd0, bus_s.branch_count}, sat(m_bc, 64'd15));
    chk("s_mispredict_count", {60'd0, bus_s.mispredict_count}, sat(m_mc, 64'd15));
    chk("s_flush", {63'd0, bus_s.flush}, {63'd0, m_flush_left > 0});
  endtask

  // One clock: model advances on the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic fetch_to_ex(input bit pred);
    drive(0, 1, pred, 0, 0, '0, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    cycle();
  endtask

  initial begin
    logic [63:0] pc, tgt;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0, '0);
    model_reset();
    @(negedge clk);

    // Reset and steady state
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Correct taken prediction
    fetch_to_ex(1'b1);
    drive(0, 0, 0, 1, 1, 64'h800, 64'h900);
    cycle();
    chk("t2_branchex", {63'd0, bus.branchex}, 64'd1);
    chk("t2_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
    chk("t2_branch_count", {32'd0, bus.branch_count}, 64'd1);
    drive(0, 0, 0, 0, 0, '0, '0);
    cycle();

    // Mispredict not-taken; younger fetches must be squashed
    fetch_to_ex(1'b1);
    drive(0, 1, 1, 1, 0, 64'h1000, 64'h3000);
    cycle();
    chk("t3_redirect_pc", bus.redirect_pc, 64'h1004);
    chk("t3_redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
    chk("t3_flush_1", {63'd0, bus.flush}, 64'd1);
    cycle();
    chk("t3_flush_2", {63'd0, bus.flush}, 64'd1);
    chk("t3_no_resolve", {63'd0, bus.branchex}, 64'd0);
    cycle();
    chk("t3_flush_end", {63'd0, bus.flush}, 64'd0);
    chk("t3_mispredict_count", {32'd0, bus.mispredict_count}, 64'd1);
    drive(0, 0, 0, 0, 0, '0, '0);
    repeat (4) cycle();

    // Taken mispredict held off by stall, then stall during flush
    fetch_to_ex(1'b0);
    drive(1, 0, 0, 1, 1, 64'h5000, 64'h2040);
    cycle();
    chk("t4_stalled", {63'd0, bus.branchex}, 64'd0);
    drive(0, 0, 0, 1, 1, 64'h5000, 64'h2040);
    cycle();
    chk("t4_redirect_pc", bus.redirect_pc, 64'h2040);
    chk("t4_flush_1", {63'd0, bus.flush}, 64'd1);
    drive(1, 0, 0, 0, 0, '0, '0);
    cycle();
    chk("t4_flush_2", {63'd0, bus.flush}, 64'd1);
    cycle();
    chk("t4_flush_end", {63'd0, bus.flush}, 64'd0);
    drive(0, 0, 0, 0, 0, '0, '0);
    repeat (2) cycle();

    // Bubble in EX, then asynchronous reset mid-flush
    drive(0, 0, 0, 1, 1, 64'h10, 64'h20);
    cycle();
    chk("t5_bubble", {63'd0, bus.branchex}, 64'd0);
    fetch_to_ex(1'b1);
    drive(0, 0, 0, 1, 0, 64'h7000, 64'h7100);
    cycle();
    chk("t5_flushing", {63'd0, bus.flush}, 64'd1);
    drive(0, 0, 0, 0, 0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_flush", {63'd0, bus.flush}, 64'd0);
    chk("t5_rst_redirect", {63'd0, bus.redirect_valid}, 64'd0);
    chk("t5_rst_bcount", {32'd0, bus.branch_count}, 64'd0);
    chk("t5_rst_mcount", {32'd0, bus.mispredict_count}, 64'd0);
    cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Saturation of the 4-bit counters
    for (int i = 0; i < 16; i++) begin
      fetch_to_ex(1'b1);
      drive(0, 0, 0, 1, 0, 64'(i) << 4, 64'h9000);
      cycle();
      drive(0, 0, 0, 0, 0, '0, '0);
      repeat (2) cycle();
    end
    chk("t6_s_mcount", {60'd0, bus_s.mispredict_count}, 64'hF);
    chk("t6_s_bcount", {60'd0, bus_s.branch_count}, 64'hF);
    chk("t6_mcount", {32'd0, bus.mispredict_count}, 64'd16);

    // Randomized traffic, including PC wrap-around
    for (int i = 0; i < 400; i++) begin
      pc  = {$urandom, $urandom};
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
      drive($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, 1'($urandom), pc, tgt);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Downstream partner of the 2-bit branch predictor in the pipelined RISC-V core.
- Carries each fetched prediction through the IF->ID->EX pipeline and compares it with the branch outcome computed in EX.
- On a mispredict it issues a front-end redirect and flush.
- Drives the predictor's update strobe (branchex/outcome) and keeps prediction statistics.

Parameters:
- PC_W, 64, program counter and target width.
- CNT_W, 32, width of the statistics counters.
- FLUSH_CYCLES, 2, number of cycles flush is held high after a mispredict; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; freezes the metadata pipe and resolution.
- if_valid  in  1  IF stage holds a real instruction.
- if_prediction  in  1  predictor output for the fetched instruction; 1 = taken.
- ex_branch  in  1  instruction in EX is a conditional branch.
- ex_taken  in  1  actual branch outcome computed in EX.
- ex_pc  in  PC_W  PC of the instruction in EX.
- ex_target  in  PC_W  computed taken-target of the branch in EX.
- branchex  out  1  predictor update strobe; one-cycle pulse per resolved branch.
- outcome  out  1  resolved outcome paired with branchex.
- flush  out  1  kill the IF/ID instructions while high.
- redirect_valid  out  1  one-cycle pulse; the front end loads redirect_pc.
- redirect_pc  out  PC_W  corrected fetch address.
- branch_count  out  CNT_W  number of resolved branches.
- mispredict_count  out  CNT_W  number of mispredicted branches.

Behaviour:
- Reset is asynchronous on rst_n low. All outputs go to 0, all metadata valid bits go to 0, and the FSM goes to IDLE.
- Metadata pipe has two stages, ID and EX, each holding {valid, pred}.
  - When stall=0 and flush=0: ID <= {if_valid, if_prediction}; EX <= ID.
  - When stall=1 and flush=0: both stages hold.
  - When flush=1: ID.valid and EX.valid are cleared every cycle, whether or not stall is asserted. Flush wins over stall.
- A branch resolves in a cycle when ex_branch=1, EX.valid=1, stall=0 and the FSM is in IDLE. In any other case ex_branch is ignored.
- On resolve, mispredict = (EX.pred != ex_taken).
- Resolution outputs are registered, with a latency of 1 cycle after the resolve edge:
  - branchex=1 and outcome=ex_taken for exactly one cycle. This happens for every resolve, whether predicted correctly or not.
  - branch_count increments by 1.
  - If mispredict: mispredict_count increments by 1, and redirect_valid=1 for one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4. The +4 addition is modulo 2^PC_W.
  - If mispredict: the FSM enters FLUSH.
  - redirect_pc holds its last value when redirect_valid=0.
  - outcome holds its last value when branchex=0.
- FSM:
  - IDLE: flush=0. On a mispredict resolve, go to FLUSH and load the cycle counter with FLUSH_CYCLES-1.
  - FLUSH: flush=1. The counter decrements each cycle, ignoring stall. When the counter reaches 0, return to IDLE on the next edge.
  - Flush is asserted the same cycle as redirect_valid and stays high for exactly FLUSH_CYCLES cycles.
  - No resolve is accepted during FLUSH; EX.valid is 0 anyway.
- Both counters saturate at all-ones and never wrap.
- A stall arriving the cycle after a resolve does not suppress the already-registered pulses.
- If rst_n is asserted mid-FLUSH, the FSM is forced to IDLE, flush=0, and no pending pulse survives.
- A back-to-back branch in ID behind a mispredicted branch is squashed by flush and never resolves.

Test Plan:
1. Reset then steady state: rst_n low for 3 cycles, release with no branches -> all outputs 0, counts 0.
2. Correct prediction: if_prediction=1 flows to EX, ex_branch=1, ex_taken=1 -> one cycle later branchex=1, outcome=1, redirect_valid=0, flush=0, branch_count=1, mispredict_count=0.
3. Mispredict not-taken: pred=1, ex_taken=0, ex_pc=0x1000 -> redirect_valid pulse with redirect_pc=0x1004, flush high 2 cycles, the next two ID/EX entries invalid, mispredict_count=1.
4. Mispredict taken with stall: pred=0, ex_taken=1, ex_target=0x2040, stall=1 in the resolve cycle -> no resolve. Release stall -> resolve, redirect_pc=0x2040. Assert stall during FLUSH -> flush still lasts exactly 2 cycles.
5. Bubble and async reset: ex_branch=1 with EX.valid=0 -> no branchex. Later, rst_n pulses low (async, between edges) during FLUSH -> flush drops immediately and counters clear.
6. Saturation: preload via 2^CNT_W-1 resolves in a bench with CNT_W=4 -> after 16 mispredicts both counters read 0xF.
